row_vector_dot_engine: RTL and testbench

Parametrised integer dot-product engine that multiplies one matrix row by the matching vector segment in chunks of NI element pairs. It accumulates across a programmable number of chunks ("multiples") and returns one scalar per row. It sits between the row/vector fetch logic and the result decoder in the mat-vec datapath. It adds valid/ready back-pressure on input and output, a pipelined adder tree sized by NI, and overflow reporting.

---
 rtl/row_vector_pkg.sv | 21 ++
 rtl/row_vector_adder_tree.sv | 47 ++++
 rtl/row_vector_dot_engine.sv | 164 ++++++++++++++++
 tb/tb_row_vector_dot_engine.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_vector_pkg.sv
// Shared types and elaboration helpers for the row/vector dot-product engines.
package row_vector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEFAULT_NI  = 8;
  localparam int TREE_STAGES = clog2(DEFAULT_NI);

endpackage

// File: rtl/row_vector_adder_tree.sv
// Pipelined binary reduction of N signed values; one register level per tree level.
module row_vector_adder_tree
  import row_vector_pkg::*;
#(
  parameter int N      = DEFAULT_NI,
  parameter int IN_W   = 64,
  parameter int STAGES = TREE_STAGES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [N-1:0][IN_W-1:0]   i_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic [IN_W+STAGES-1:0]   o_sum
);

  localparam int OUT_W = IN_W + STAGES;

  // Heap layout: node k sums children 2k and 2k+1; indices N..2N-1 are the leaves.
  logic signed [OUT_W-1:0] r_node [1:N-1];
  logic signed [OUT_W-1:0] w_all  [2:2*N-1];
  logic [STAGES-1:0]       r_vld_pipe;

  for (genvar k = 2; k < 2*N; k++) begin : g_all
    if (k < N) begin : g_inner
      assign w_all[k] = r_node[k];
    end else begin : g_leaf
      assign w_all[k] = OUT_W'($signed(i_data[k-N]));
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k < N; k++)
      r_node[k] <= w_all[2*k] + w_all[2*k+1];
  end

  always_ff @(posedge clk) begin
    if (!reset) r_vld_pipe <= '0;
    else        r_vld_pipe <= STAGES'({r_vld_pipe, i_valid});
  end

  assign o_sum   = r_node[1];
  assign o_valid = r_vld_pipe[STAGES-1];
  assign o_busy  = |r_vld_pipe;

endmodule

// File: rtl/row_vector_dot_engine.sv
// Row x vector-segment dot product: multiply stage, adder tree, accumulator, result hold.
module row_vector_dot_engine
  import row_vector_pkg::*;
#(
  parameter int NI              = DEFAULT_NI,
  parameter int ELEMENT_WIDTH   = 32,
  parameter int MULTIPLES_WIDTH = 3,
  parameter int ACC_WIDTH       = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MULTIPLES_WIDTH-1:0]    no_of_multiples,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NI*ELEMENT_WIDTH-1:0]   a,
  input  logic [NI*ELEMENT_WIDTH-1:0]   p,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          result,
  output logic                          overflow,
  output logic                          idle
);

  localparam int STAGES = clog2(NI);
  localparam int PROD_W = 2 * ELEMENT_WIDTH;
  localparam int SUM_W  = PROD_W + STAGES;

  state_e                        r_state;
  logic [MULTIPLES_WIDTH-1:0]    r_cnt;
  logic                          r_in_ready, r_out_valid, r_idle, r_overflow;
  logic [ACC_WIDTH-1:0]          r_result;

  logic [NI-1:0][PROD_W-1:0]     w_prod;
  logic                          r_m_vld;
  logic [SUM_W-1:0]              w_sum;
  logic                          w_sum_vld, w_tree_busy;
  logic [ACC_WIDTH-1:0]          w_sum_ext, w_acc_next, r_acc;
  logic                          w_sum_fits, w_acc_ovf, r_acc_ovf, r_acc_vld;
  logic                          w_accept, w_start_ok, w_busy;

  assign w_accept   = in_valid && r_in_ready;
  assign w_start_ok = start && (r_state == IDLE || (r_state == HOLD && out_ready));
  assign w_busy     = r_m_vld || w_tree_busy || r_acc_vld;

  // Operands are sign-extended first so the low PROD_W bits are the exact product.
  for (genvar i = 0; i < NI; i++) begin : g_mul
    logic signed [PROD_W-1:0] w_ax, w_px, r_prod;
    assign w_ax = PROD_W'($signed(a[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
    assign w_px = PROD_W'($signed(p[i*ELEMENT_WIDTH +: ELEMENT_WIDTH]));
    always_ff @(posedge clk) r_prod <= w_ax * w_px;
    assign w_prod[i] = r_prod;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_m_vld <= 1'b0;
    else        r_m_vld <= w_accept;
  end

  row_vector_adder_tree #(
    .N      (NI),
    .IN_W   (PROD_W),
    .STAGES (STAGES)
  ) u_tree (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_m_vld),
    .i_data  (w_prod),
    .o_valid (w_sum_vld),
    .o_busy  (w_tree_busy),
    .o_sum   (w_sum)
  );

  // A tree sum fits iff every bit above the accumulator sign bit matches it.
  if (SUM_W > ACC_WIDTH) begin : g_narrow
    assign w_sum_ext  = w_sum[ACC_WIDTH-1:0];
    assign w_sum_fits = (w_sum[SUM_W-1:ACC_WIDTH-1] == '0) || (&w_sum[SUM_W-1:ACC_WIDTH-1]);
  end else begin : g_wide
    assign w_sum_ext  = ACC_WIDTH'($signed(w_sum));
    assign w_sum_fits = 1'b1;
  end

  assign w_acc_next = r_acc + w_sum_ext;
  assign w_acc_ovf  = (r_acc[ACC_WIDTH-1] == w_sum_ext[ACC_WIDTH-1]) &&
                      (w_acc_next[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

  // The pipeline is always empty when a start is honoured, so clearing here loses nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
      r_acc_vld <= 1'b0;
    end else begin
      r_acc_vld <= w_sum_vld;
      if (w_start_ok) begin
        r_acc     <= '0;
        r_acc_ovf <= 1'b0;
      end else if (w_sum_vld) begin
        r_acc     <= w_acc_next;
        r_acc_ovf <= r_acc_ovf | w_acc_ovf | ~w_sum_fits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_start_ok) begin
            r_idle <= 1'b0;
            if (no_of_multiples == '0) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_result    <= '0;
              r_overflow  <= 1'b0;
            end else begin
              r_state     <= LOAD;
              r_cnt       <= no_of_multiples;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
            end
          end else if (r_state == HOLD && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_idle      <= 1'b1;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == MULTIPLES_WIDTH'(1)) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!w_busy) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_result    <= r_acc;
            r_overflow  <= r_acc_ovf;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign overflow  = r_overflow;
  assign idle      = r_idle;

endmodule

// File: tb/tb_row_vector_dot_engine.sv
// Scoreboard bench: default engine plus a 16-bit-accumulator copy sharing the same stimulus.
module tb_row_vector_dot_engine;

  localparam int NI = 8;
  localparam int EW = 32;
  localparam int MW = 3;
  localparam int DW = NI * EW;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [MW-1:0] nom = '0;
  logic [DW-1:0] a = '0, p = '0;
  logic          in_ready, out_valid, overflow, idle;
  logic [63:0]   result;
  logic          in_ready16, out_valid16, overflow16, idle16;
  logic [15:0]   result16;

  always #5 clk = ~clk;

  row_vector_dot_engine #(.NI(NI), .ELEMENT_WIDTH(EW), .MULTIPLES_WIDTH(MW), .ACC_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .no_of_multiples(nom),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .p(p),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .idle(idle));

  row_vector_dot_engine #(.NI(NI), .ELEMENT_WIDTH(EW), .MULTIPLES_WIDTH(MW), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start), .no_of_multiples(nom),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .p(p),
    .out_valid(out_valid16), .out_ready(out_ready), .result(result16),
    .overflow(overflow16), .idle(idle16));

  int n_vec = 0, n_bad = 0;
  int cycle = 0, last_acc = 0, n_acc = 0;
  logic [DW-1:0] ca [4];
  logic [DW-1:0] cp [4];
  logic [63:0]   q_res[$];
  logic          q_ovf[$];
  logic [15:0]   q_res16[$];
  logic          q_ovf16[$];

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (in_valid && in_ready) begin
      last_acc <= cycle + 1;
      n_acc    <= n_acc + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [127:0] wrapw(input logic signed [127:0] x, input int w);
    logic signed [127:0] t;
    t = x <<< (128 - w);
    return t >>> (128 - w);
  endfunction

  // Exact wide-integer reference for both accumulator widths.
  task automatic push_exp(input int n);
    logic signed [127:0] acc, s, hi, lo;
    bit ov;
    int w;
    for (int wi = 0; wi < 2; wi++) begin
      w  = (wi == 0) ? 64 : 16;
      hi = (128'sd1 <<< (w - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (w - 1));
      acc = '0;
      ov  = 1'b0;
      for (int k = 0; k < n; k++) begin
        s = '0;
        for (int i = 0; i < NI; i++)
          s = s + 128'($signed(ca[k][i*EW +: EW])) * 128'($signed(cp[k][i*EW +: EW]));
        if (s > hi || s < lo) ov = 1'b1;
        acc = acc + wrapw(s, w);
        if (acc > hi || acc < lo) ov = 1'b1;
        acc = wrapw(acc, w);
      end
      if (wi == 0) begin q_res.push_back(acc[63:0]); q_ovf.push_back(ov); end
      else         begin q_res16.push_back(acc[15:0]); q_ovf16.push_back(ov); end
    end
  endtask

  task automatic fill(input int k, input int av, input int pbase, input int pstep);
    for (int i = 0; i < NI; i++) begin
      ca[k][i*EW +: EW] = EW'(av);
      cp[k][i*EW +: EW] = EW'(pbase + i * pstep);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    nom   = MW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit bub, output bit ok);
    int k, c;
    k = 0;
    c = 0;
    while (k < n && c < 100) begin
      if (bub && (c % 2 == 1)) in_valid = 1'b0;
      else begin
        a = ca[k];
        p = cp[k];
        in_valid = 1'b1;
        if (in_ready) k++;
      end
      c++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    ok = (k == n);
  endtask

  task automatic wait_out(output bit ok);
    int c;
    c = 0;
    while (!out_valid && c < 60) begin
      @(negedge clk);
      c++;
    end
    ok = out_valid;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if ({in_ready, out_valid, overflow, idle} !== 4'b0001) begin n_bad++;
      $display("FAIL reset_flags got %b want 0001", {in_ready, out_valid, overflow, idle}); end
    n_vec++; if (result !== 64'd0) begin n_bad++;
      $display("FAIL reset_result got %h want 0", result); end
    n_vec++; if ({in_ready16, out_valid16, overflow16, idle16, result16} !== {4'b0001, 16'd0}) begin n_bad++;
      $display("FAIL reset_dut16 got %b %h", {in_ready16, out_valid16, overflow16, idle16}, result16); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if ({in_ready, out_valid, idle} !== 3'b001) begin n_bad++;
      $display("FAIL post_reset_idle got %b want 001", {in_ready, out_valid, idle}); end
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    fill(0, 1, 1, 1);
    push_exp(1);
    do_start(1);
    n_vec++; if (in_ready !== 1'b1 || idle !== 1'b0) begin n_bad++;
      $display("FAIL single_in_ready got %b idle %b want 1 0", in_ready, idle); end
    feed(1, 1'b0, ok);
    wait_out(ok);
    lat = cycle - last_acc;
    n_vec++; if (!ok || lat != 6) begin n_bad++;
      $display("FAIL single_latency got %0d (seen %0b) want 6", lat, ok); end
    n_vec++; if (result !== q_res[0] || result !== 64'd36) begin n_bad++;
      $display("FAIL single_result got %0d want %0d", result, q_res[0]); end
    n_vec++; if (overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL single_ovf got %b want %b", overflow, q_ovf[0]); end
    n_vec++; if (out_valid16 !== 1'b1 || result16 !== q_res16[0] || overflow16 !== q_ovf16[0]) begin n_bad++;
      $display("FAIL single_dut16 got %b %h %b want 1 %h %b", out_valid16, result16, overflow16, q_res16[0], q_ovf16[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
    n_vec++; if (out_valid !== 1'b0 || idle !== 1'b1) begin n_bad++;
      $display("FAIL single_release got ov %b idle %b want 0 1", out_valid, idle); end
  endtask

  task automatic test_bubbles();
    bit ok;
    int acc0;
    for (int k = 0; k < 3; k++) fill(k, k + 1, 2, 0);
    push_exp(3);
    acc0 = n_acc;
    do_start(3);
    feed(3, 1'b1, ok);
    n_vec++; if (!ok || n_acc - acc0 != 3) begin n_bad++;
      $display("FAIL bubble_accepts got %0d want 3", n_acc - acc0); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL bubble_in_ready got %b want 0", in_ready); end
    wait_out(ok);
    n_vec++; if (!ok || result !== q_res[0] || result !== 64'd96 || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL bubble_result got %0d/%b want %0d/%b", result, overflow, q_res[0], q_ovf[0]); end
    n_vec++; if (result16 !== q_res16[0] || overflow16 !== q_ovf16[0]) begin n_bad++;
      $display("FAIL bubble_dut16 got %h/%b want %h/%b", result16, overflow16, q_res16[0], q_ovf16[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
  endtask

  task automatic test_signed_hold();
    bit ok, stable;
    logic [63:0] r0;
    fill(0, -3, 5, 0);
    fill(1, -3, 5, 0);
    push_exp(2);
    do_start(2);
    feed(2, 1'b0, ok);
    wait_out(ok);
    n_vec++; if (!ok || result !== q_res[0] || $signed(result) != -240 || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL signed_result got %0d/%b want %0d/%b", $signed(result), overflow, $signed(q_res[0]), q_ovf[0]); end
    r0 = result;
    stable = 1'b1;
    start = 1'b1;
    nom = MW'(1);
    repeat (10) begin
      @(negedge clk);
      if (result !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0 || idle !== 1'b0) stable = 1'b0;
    end
    start = 1'b0;
    n_vec++; if (!stable) begin n_bad++;
      $display("FAIL hold_stable got res %h ov %b rdy %b want %h 1 0", result, out_valid, in_ready, r0); end
    n_vec++; if (result16 !== q_res16[0] || overflow16 !== q_ovf16[0]) begin n_bad++;
      $display("FAIL signed_dut16 got %h/%b want %h/%b", result16, overflow16, q_res16[0], q_ovf16[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
  endtask

  task automatic test_overflow();
    bit ok;
    fill(0, 32'h7FFF, 32'h7FFF, 0);
    push_exp(1);
    do_start(1);
    feed(1, 1'b0, ok);
    wait_out(ok);
    n_vec++; if (!ok || result16 !== q_res16[0] || overflow16 !== q_ovf16[0] || overflow16 !== 1'b1) begin n_bad++;
      $display("FAIL ovf16 got %h/%b want %h/%b", result16, overflow16, q_res16[0], q_ovf16[0]); end
    n_vec++; if (result !== q_res[0] || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL ovf64 got %h/%b want %h/%b", result, overflow, q_res[0], q_ovf[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_exp(0);
    do_start(0);
    n_vec++; if (out_valid !== 1'b1 || result !== q_res[0] || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL zero_row got ov %b res %h/%b want 1 %h/%b", out_valid, result, overflow, q_res[0], q_ovf[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    fill(0, 7, -4, 1);
    push_exp(1);
    out_ready = 1'b1;
    start = 1'b1;
    nom = MW'(1);
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || idle !== 1'b0) begin n_bad++;
      $display("FAIL b2b_start got rdy %b ov %b idle %b want 1 0 0", in_ready, out_valid, idle); end
    feed(1, 1'b0, ok);
    wait_out(ok);
    n_vec++; if (!ok || result !== q_res[0] || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL b2b_result got %h/%b want %h/%b", result, overflow, q_res[0], q_ovf[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
  endtask

  task automatic test_reset_mid_row();
    bit ok;
    for (int k = 0; k < 4; k++) fill(k, 100 + k, 9, 3);
    do_start(4);
    feed(2, 1'b0, ok);
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if ({idle, out_valid, in_ready, overflow} !== 4'b1000 || result !== 64'd0) begin n_bad++;
      $display("FAIL mid_reset got %b res %h want 1000 0", {idle, out_valid, in_ready, overflow}, result); end
    reset = 1'b1;
    fill(0, -2, 11, -1);
    push_exp(1);
    do_start(1);
    feed(1, 1'b0, ok);
    wait_out(ok);
    n_vec++; if (!ok || result !== q_res[0] || overflow !== q_ovf[0]) begin n_bad++;
      $display("FAIL post_reset_row got %h/%b want %h/%b", result, overflow, q_res[0], q_ovf[0]); end
    n_vec++; if (result16 !== q_res16[0] || overflow16 !== q_ovf16[0]) begin n_bad++;
      $display("FAIL post_reset_dut16 got %h/%b want %h/%b", result16, overflow16, q_res16[0], q_ovf16[0]); end
    void'(q_res.pop_front()); void'(q_ovf.pop_front()); void'(q_res16.pop_front()); void'(q_ovf16.pop_front());
    ack();
    n_vec++; if (q_res.size() != 0 || idle !== 1'b1) begin n_bad++;
      $display("FAIL drain_end got q %0d idle %b want 0 1", q_res.size(), idle); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bubbles();
    test_signed_hold();
    test_overflow();
    test_back_to_back();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
